// File: rtl/uart_tx_arbiter_if.sv
// Requester-side and UART-side signals of the shared UART transmit arbiter.
// The slave modport is the arbiter; the master modport is its environment.
interface uart_tx_arbiter_if #(
  parameter int N_REQ = 4
);
  logic [N_REQ-1:0]   req;
  logic [8*N_REQ-1:0] req_byte;
  logic [N_REQ-1:0]   req_last;
  logic [N_REQ-1:0]   ack;
  logic [N_REQ-1:0]   grant;
  logic               uart_transmit;
  logic [7:0]         uart_tx_byte;
  logic               uart_is_transmitting;
  logic               busy_err;
  logic               abort;

  modport master (
    output req, req_byte, req_last, uart_is_transmitting,
    input  ack, grant, uart_transmit, uart_tx_byte, busy_err, abort
  );

  modport slave (
    input  req, req_byte, req_last, uart_is_transmitting,
    output ack, grant, uart_transmit, uart_tx_byte, busy_err, abort
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among N_REQ byte streams;
// the winner keeps the UART until the last byte of its message is sent.
//
// state     | meaning
// IDLE      | no owner; arbitrate once the UART is idle
// ISSUE     | transmit and ack pulse for the captured byte
// WAIT_BUSY | waiting for the UART to report busy (BUSY_TIMEOUT guard)
// WAIT_DONE | UART busy with the byte; decide release/next byte/hold
// HOLD      | owner mid-message with req low (HOLD_TIMEOUT guard)
module uart_tx_arbiter #(
  parameter int N_REQ        = 4,
  parameter int BUSY_TIMEOUT = 16,
  parameter int HOLD_TIMEOUT = 65535
) (
  input  logic              clk,
  input  logic              rst,
  uart_tx_arbiter_if.slave  bus
);
  localparam int          OW       = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam logic [15:0] BUSY_LIM = 16'(BUSY_TIMEOUT - 1);
  localparam logic [15:0] HOLD_LIM = 16'(HOLD_TIMEOUT - 1);

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT_BUSY, WAIT_DONE, HOLD} state_t;

  state_t           state_q, state_d;
  logic [OW-1:0]    owner_q, owner_d;
  logic [OW-1:0]    rr_q, rr_d;
  logic             last_q, last_d;
  logic [15:0]      cnt_q, cnt_d;
  logic [N_REQ-1:0] ack_q, ack_d;
  logic [N_REQ-1:0] grant_q, grant_d;
  logic             xmit_q, xmit_d;
  logic [7:0]       byte_q, byte_d;
  logic             berr_q, berr_d;
  logic             abort_q, abort_d;

  logic [OW-1:0]    pick, scan, rr_next;
  logic             pick_vld;
  logic             own_req, own_last;
  logic [7:0]       own_byte;

  // Scan downward so the requester closest to the pointer is assigned last.
  always_comb begin
    pick     = '0;
    pick_vld = 1'b0;
    scan     = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      scan = (int'(rr_q) + k >= N_REQ) ? OW'(int'(rr_q) + k - N_REQ)
                                       : OW'(int'(rr_q) + k);
      if (bus.req[scan]) begin
        pick     = scan;
        pick_vld = 1'b1;
      end
    end
  end

  assign own_req  = bus.req[owner_q];
  assign own_last = bus.req_last[owner_q];
  assign own_byte = bus.req_byte[{owner_q, 3'b000} +: 8];
  assign rr_next  = (owner_q == OW'(N_REQ - 1)) ? '0 : owner_q + 1'b1;

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    rr_d    = rr_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    grant_d = grant_q;
    byte_d  = byte_q;
    ack_d   = '0;
    xmit_d  = 1'b0;
    berr_d  = 1'b0;
    abort_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (pick_vld && !bus.uart_is_transmitting) begin
          owner_d = pick;
          grant_d = N_REQ'(1) << pick;
          ack_d   = N_REQ'(1) << pick;
          byte_d  = bus.req_byte[{pick, 3'b000} +: 8];
          last_d  = bus.req_last[pick];
          xmit_d  = 1'b1;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        cnt_d   = '0;
        state_d = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        if (bus.uart_is_transmitting) begin
          state_d = WAIT_DONE;
        end else if (cnt_q == BUSY_LIM) begin
          berr_d  = 1'b1;
          grant_d = '0;
          rr_d    = rr_next;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      WAIT_DONE: begin
        // last_q wins over a pending req so a new message is re-arbitrated.
        if (!bus.uart_is_transmitting) begin
          if (last_q) begin
            grant_d = '0;
            rr_d    = rr_next;
            state_d = IDLE;
          end else if (own_req) begin
            byte_d  = own_byte;
            last_d  = own_last;
            ack_d   = grant_q;
            xmit_d  = 1'b1;
            state_d = ISSUE;
          end else begin
            cnt_d   = '0;
            state_d = HOLD;
          end
        end
      end
      HOLD: begin
        if (own_req) begin
          byte_d  = own_byte;
          last_d  = own_last;
          ack_d   = grant_q;
          xmit_d  = 1'b1;
          state_d = ISSUE;
        end else if (cnt_q == HOLD_LIM) begin
          abort_d = 1'b1;
          grant_d = '0;
          rr_d    = rr_next;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      owner_q <= '0;
      rr_q    <= '0;
      last_q  <= 1'b0;
      cnt_q   <= '0;
      ack_q   <= '0;
      grant_q <= '0;
      xmit_q  <= 1'b0;
      byte_q  <= '0;
      berr_q  <= 1'b0;
      abort_q <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      rr_q    <= rr_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      ack_q   <= ack_d;
      grant_q <= grant_d;
      xmit_q  <= xmit_d;
      byte_q  <= byte_d;
      berr_q  <= berr_d;
      abort_q <= abort_d;
    end
  end

  assign bus.ack           = ack_q;
  assign bus.grant         = grant_q;
  assign bus.uart_transmit = xmit_q;
  assign bus.uart_tx_byte  = byte_q;
  assign bus.busy_err      = berr_q;
  assign bus.abort         = abort_q;
endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
Shares one uart transmitter among N_REQ byte-stream requesters using round-robin arbitration with message locking. A message is one or more bytes, and its last byte is flagged. The block sequences the UART's transmit/tx_byte/is_transmitting handshake one byte at a time. A requester that wins keeps the transmitter until its last byte completes, so messages never interleave on the serial line. It sits between the UART instance and on-chip sources such as a debug monitor, status reporter and command responder.

Parameters:
N_REQ, 4, number of requesters (2..8).
BUSY_TIMEOUT, 16, clk cycles allowed after an issued byte for uart_is_transmitting to rise before flagging an error.
HOLD_TIMEOUT, 65535, clk cycles a locked owner may leave req low mid-message before the lock is forcibly released (16-bit counter).

Ports:
clk  in  1  master clock
rst  in  1  reset, asynchronous, active-high
req  in  N_REQ  per-requester byte valid
req_byte  in  8*N_REQ  per-requester byte; requester i uses bits [8i+7:8i]
req_last  in  N_REQ  per-requester flag: the presented byte ends the message
ack  out  N_REQ  one-cycle pulse: the presented byte of requester i was accepted
grant  out  N_REQ  one-hot current owner; all zero when unlocked
uart_transmit  out  1  to UART transmit
uart_tx_byte  out  8  to UART tx_byte
uart_is_transmitting  in  1  from UART is_transmitting
busy_err  out  1  one-cycle pulse: UART failed to go busy within BUSY_TIMEOUT
abort  out  1  one-cycle pulse: locked message abandoned by HOLD_TIMEOUT

Behaviour:
- All outputs are registered. While rst is high: state=IDLE, all outputs 0, rr pointer=0, counters=0.
- States: IDLE, ISSUE, WAIT_BUSY, WAIT_DONE, HOLD.
- IDLE:
  - When any req is high and uart_is_transmitting=0, pick the first requesting index at or after the rr pointer, scanning upward with wrap.
  - Set owner and grant.
  - Capture req_byte[owner] into uart_tx_byte and req_last[owner] into last_q.
  - Go to ISSUE.
  - If uart_is_transmitting=1, stay in IDLE.
- ISSUE (exactly one cycle): uart_transmit=1 and ack[owner]=1. Go to WAIT_BUSY and clear the counter.
- WAIT_BUSY:
  - On uart_is_transmitting=1, go to WAIT_DONE.
  - Otherwise increment the counter. When it reaches BUSY_TIMEOUT, pulse busy_err, release the lock, and go to IDLE.
- WAIT_DONE: wait for uart_is_transmitting=0. The UART's stop-bit delay is included in its busy time, so no extra wait is needed. Then:
  - last_q=1: release the lock and go to IDLE.
  - else req[owner]=1: capture the new byte and last flag, then go to ISSUE.
  - else: go to HOLD and clear the counter.
- HOLD:
  - On req[owner]=1, capture and go to ISSUE.
  - Otherwise increment the counter. When it reaches HOLD_TIMEOUT, pulse abort, release the lock, and go to IDLE.
  - Other requesters are ignored while in HOLD.
- Release: grant goes to 0 and rr pointer = (owner+1) mod N_REQ, in the same cycle as the transition to IDLE.
- Latency: req rises with the system idle → uart_transmit is high 1 cycle later. Minimum gap between UART idle and the next transmit is 1 cycle.
- Handshake:
  - The requester holds req_byte and req_last stable while req=1 until ack.
  - After ack, it may present the next byte on the following cycle or drop req.
  - Deasserting req of a non-owner before grant is legal and produces no effect.
- ack and uart_transmit are never high outside ISSUE. At most one ack bit is high, and at most one transmit occurs per UART busy period.
- Simultaneous events:
  - A req rising in the same cycle as a release is arbitrated in the next IDLE cycle, using the updated pointer.
  - In WAIT_DONE, last_q takes priority over req.
- Reset asserted mid-byte: outputs clear immediately. The UART's own in-flight frame is not controlled by this block.

Test Plan:
- Single requester: req[0]=1, byte 0x55, last=1 with a UART model busy for 40 cycles → one ack[0], uart_transmit one cycle, uart_tx_byte=0x55, grant=0001 then 0000; pointer=1.
- Round-robin: req[3:0]=1111, all single-byte messages → grant order 0,1,2,3,0; each byte issued only after is_transmitting falls.
- Lock: req[1] sends 3 bytes 0xA1,0xA2,0xA3 (last on 0xA3) while req[2]=1 throughout → UART sees A1,A2,A3 consecutively, then requester 2's byte.
- HOLD timeout with HOLD_TIMEOUT=20: owner 0 sends a non-last byte, then drops req → abort pulses exactly 20 cycles after entering HOLD, grant clears, requester 1 is then served.
- busy_err with BUSY_TIMEOUT=16: UART model never raises is_transmitting → busy_err pulses once 16 cycles after ISSUE, state returns to IDLE, next requester served.
- Async reset during WAIT_DONE → grant, ack, uart_transmit all 0 without a clock edge; after release, req[0] is arbitrated first.
